// File: rtl/lmc_pkg.sv
// lmc_pkg: opcode constants and FSM state encoding shared by the LMC sequencer and its ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lmc_pkg;

  // Instruction opcodes, carried in ir[7:4].
  localparam logic [3:0] HLT = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] STA = 4'h3;
  localparam logic [3:0] LDA = 4'h5;
  localparam logic [3:0] BRA = 4'h6;
  localparam logic [3:0] BRZ = 4'h7;
  localparam logic [3:0] BRP = 4'h8;
  localparam logic [3:0] OUT = 4'h9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/lmc_alu.sv
// lmc_alu: accumulator arithmetic for ADD/SUB/LDA; any other opcode passes acc through.
// Latency: combinational.
// Backpressure: none.
// Ports: acc (current accumulator), operand (RAM word), opcode (ir[7:4]),
//        result (next accumulator value), neg_next (borrow flag for SUB, 0 for ADD/LDA).
module lmc_alu
  import lmc_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [3:0]            opcode,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  neg_next
);

  // One extra bit on the subtraction exposes the borrow in its MSB.
  logic [DATA_WIDTH:0] diff;

  assign diff = {1'b0, acc} - {1'b0, operand};

  always_comb begin
    result   = acc;
    neg_next = 1'b0;
    case (opcode)
      ADD: result = acc + operand;
      SUB: begin
        result   = diff[DATA_WIDTH-1:0];
        neg_next = diff[DATA_WIDTH];
      end
      LDA: result = operand;
      default: ;
    endcase
  end

endmodule

// File: rtl/lmc_sequencer.sv
// lmc_sequencer: two-cycle-per-instruction Little Man Computer sequencer driving an external async-read RAM.
// Latency: FETCH + EXEC = 2 cycles per instruction; run starts FETCH on the following cycle.
// Backpressure: loader writes accepted combinationally (load_ready) only in IDLE/HALT; ignored while executing.
// Ports: timer555 clock, reset_count sync active-high reset, run start request,
//        load_valid/load_ready/load_addr/load_data loader write, ram_addr/ram_wdata/ram_we/ram_rdata RAM,
//        pc/acc/out_data/out_valid/halted architectural status.
// Build option: LMC_SEQ_STEP_EN adds a step input; FETCH then waits for step=1 (single-step execution).
module lmc_sequencer
  import lmc_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  timer555,
  input  logic                  reset_count,
  input  logic                  run,
`ifdef LMC_SEQ_STEP_EN
  input  logic                  step,
`endif
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] acc,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  halted
);

  state_t                state, state_next;
  logic [DATA_WIDTH-1:0] ir, ir_next;
  logic                  neg, neg_next;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [DATA_WIDTH-1:0] acc_next;
  logic [DATA_WIDTH-1:0] out_data_next;
  logic                  out_valid_next;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand_addr;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_neg;
  logic                  fetch_go;

  assign opcode       = ir[7:4];
  assign operand_addr = ADDR_WIDTH'(ir[3:0]);
  assign halted       = (state == HALT);

`ifdef LMC_SEQ_STEP_EN
  assign fetch_go = step;
`else
  assign fetch_go = 1'b1;
`endif

  lmc_alu #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_alu (
    .acc      (acc),
    .operand  (ram_rdata),
    .opcode   (opcode),
    .result   (alu_result),
    .neg_next (alu_neg)
  );

  always_ff @(posedge timer555) begin
    if (reset_count) begin
      state     <= IDLE;
      pc        <= '0;
      acc       <= '0;
      ir        <= '0;
      neg       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      acc       <= acc_next;
      ir        <= ir_next;
      neg       <= neg_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
    end
  end

  always_comb begin
    state_next     = state;
    pc_next        = pc;
    acc_next       = acc;
    ir_next        = ir;
    neg_next       = neg;
    out_data_next  = out_data;
    out_valid_next = 1'b0;
    ram_addr       = '0;
    ram_wdata      = '0;
    ram_we         = 1'b0;
    load_ready     = 1'b0;

    case (state)
      IDLE, HALT: begin
        // A loader write takes precedence over run in the same cycle.
        if (load_valid) begin
          load_ready = 1'b1;
          ram_we     = 1'b1;
          ram_addr   = load_addr;
          ram_wdata  = load_data;
        end else if (run) begin
          pc_next    = '0;
          state_next = FETCH;
        end
      end

      FETCH: begin
        ram_addr = pc;
        if (fetch_go) begin
          ir_next    = ram_rdata;
          pc_next    = pc + ADDR_WIDTH'(1);
          state_next = EXEC;
        end
      end

      EXEC: begin
        ram_addr   = operand_addr;
        state_next = FETCH;
        // Branch conditions look at acc/neg as registered, before this instruction updates them.
        case (opcode)
          HLT: state_next = HALT;
          ADD, SUB, LDA: begin
            acc_next = alu_result;
            neg_next = alu_neg;
          end
          STA: begin
            ram_we    = 1'b1;
            ram_wdata = acc;
          end
          BRA: pc_next = operand_addr;
          BRZ: if (acc == '0) pc_next = operand_addr;
          BRP: if (!neg) pc_next = operand_addr;
          OUT: begin
            out_data_next  = acc;
            out_valid_next = 1'b1;
          end
          default: ;
        endcase
      end

      default: state_next = IDLE;
    endcase

    // Reset wins over everything, including a write already decoded this cycle.
    if (reset_count) begin
      ram_we     = 1'b0;
      ram_wdata  = '0;
      load_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_lmc_sequencer.sv
// tb_lmc_sequencer: directed scenarios plus random programs checked against an instruction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_lmc_sequencer;

  logic       clk;
  logic       reset_count;
  logic       run;
  logic       load_valid;
  logic       load_ready;
  logic [3:0] load_addr;
  logic [7:0] load_data;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [7:0] ram_rdata;
  logic [3:0] pc;
  logic [7:0] acc;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
`ifdef LMC_SEQ_STEP_EN
  logic       step = 1'b1;
`endif

  int checks = 0;
  int errors = 0;

  // External RAM: asynchronous read, write on the rising clock edge.
  logic [7:0] mem [16];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  // Program image and instruction-level reference model state.
  logic [7:0] prog [16];
  logic [7:0] mm [16];
  int         m_pc, m_acc, m_out;
  bit         m_neg, m_halt, m_outv;

  lmc_sequencer #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .timer555    (clk),
    .reset_count (reset_count),
    .run         (run),
`ifdef LMC_SEQ_STEP_EN
    .step        (step),
`endif
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_rdata   (ram_rdata),
    .pc          (pc),
    .acc         (acc),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic instr();
    cyc();
    cyc();
  endtask

  task automatic start_run();
    run = 1'b1;
    cyc();
    run = 1'b0;
  endtask

  task automatic model_reset();
    m_pc = 0; m_acc = 0; m_out = 0; m_neg = 0; m_halt = 0; m_outv = 0;
  endtask

  task automatic reset_dut();
    reset_count = 1'b1;
    cyc();
    reset_count = 1'b0;
    model_reset();
  endtask

  task automatic load_prog();
    for (int i = 0; i < 16; i++) begin
      load_valid = 1'b1;
      load_addr  = 4'(i);
      load_data  = prog[i];
      #1;
      check("load_ready", {31'd0, load_ready}, 32'd1);
      cyc();
      mm[i] = prog[i];
    end
    load_valid = 1'b0;
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  // Executes one instruction at the ISA level.
  task automatic model_step();
    int ir, op, opd, v;
    ir     = int'(mm[m_pc]);
    m_pc   = (m_pc + 1) % 16;
    op     = ir / 16;
    opd    = ir % 16;
    v      = int'(mm[opd]);
    m_outv = 0;
    case (op)
      0: m_halt = 1;
      1: begin m_acc = (m_acc + v) % 256; m_neg = 0; end
      2: begin m_neg = (m_acc < v); m_acc = (m_acc - v + 256) % 256; end
      3: mm[opd] = 8'(m_acc);
      5: begin m_acc = v; m_neg = 0; end
      6: m_pc = opd;
      7: if (m_acc == 0) m_pc = opd;
      8: if (!m_neg) m_pc = opd;
      9: begin m_out = m_acc; m_outv = 1; end
      default: ;
    endcase
  endtask

  task automatic run_against_model();
    start_run();
    check("rnd_run_pc", {28'd0, pc}, 32'd0);
    m_pc = 0;
    m_halt = 0;
    for (int n = 0; n < 24 && !m_halt; n++) begin
      model_step();
      cyc();
      check("rnd_fetch_halted", {31'd0, halted}, 32'd0);
      cyc();
      check("rnd_pc", {28'd0, pc}, 32'(m_pc));
      check("rnd_acc", {24'd0, acc}, 32'(m_acc));
      check("rnd_out_valid", {31'd0, out_valid}, 32'(m_outv));
      check("rnd_out_data", {24'd0, out_data}, 32'(m_out));
      check("rnd_halted", {31'd0, halted}, 32'(m_halt));
    end
    for (int i = 0; i < 16; i++) check("rnd_mem", {24'd0, mem[i]}, {24'd0, mm[i]});
    if (!m_halt) reset_dut();
  endtask

  initial begin
    int n;
    int pulses;
    reset_count = 1'b1;
    run         = 1'b0;
    load_valid  = 1'b0;
    load_addr   = 4'd0;
    load_data   = 8'd0;
    cyc();
    // Reset must beat a simultaneous load request.
    load_valid = 1'b1;
    run        = 1'b1;
    #1;
    check("rst_load_ready", {31'd0, load_ready}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    cyc();
    load_valid  = 1'b0;
    run         = 1'b0;
    reset_count = 1'b0;
    model_reset();
    check("rst_pc", {28'd0, pc}, 32'd0);
    check("rst_acc", {24'd0, acc}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);

    // Single loader write in IDLE.
    load_valid = 1'b1;
    load_addr  = 4'd3;
    load_data  = 8'h5A;
    #1;
    check("ld_ready", {31'd0, load_ready}, 32'd1);
    check("ld_we", {31'd0, ram_we}, 32'd1);
    check("ld_addr", {28'd0, ram_addr}, 32'd3);
    check("ld_wdata", {24'd0, ram_wdata}, 32'h5A);
    cyc();
    load_valid = 1'b0;
    #1;
    check("ld_mem3", {24'd0, mem[3]}, 32'h5A);
    check("ld_we_after", {31'd0, ram_we}, 32'd0);

    // LDA/ADD/STA/OUT/HLT program.
    clear_prog();
    prog[0] = 8'h5A; prog[1] = 8'h1B; prog[2] = 8'h3C; prog[3] = 8'h90; prog[4] = 8'h00;
    prog[10] = 8'd7; prog[11] = 8'd5;
    load_prog();
    start_run();
    n = 0;
    pulses = 0;
    while (!halted && n < 40) begin
      cyc();
      n++;
      if (out_valid) pulses++;
    end
    check("prog_cycles", 32'(n), 32'd10);
    check("prog_acc", {24'd0, acc}, 32'd12);
    check("prog_memC", {24'd0, mem[12]}, 32'd12);
    check("prog_out_pulses", 32'(pulses), 32'd1);
    check("prog_out_data", {24'd0, out_data}, 32'd12);

    // SUB borrow, BRP not taken, BRZ taken. Loaded while HALTed.
    clear_prog();
    prog[0] = 8'h5A; prog[1] = 8'h2B; prog[2] = 8'h87; prog[3] = 8'h5C; prog[4] = 8'h78;
    prog[10] = 8'd3; prog[11] = 8'd5; prog[12] = 8'd0;
    load_prog();
    start_run();
    instr();
    check("sub_lda", {24'd0, acc}, 32'd3);
    instr();
    check("sub_acc", {24'd0, acc}, 32'hFE);
    instr();
    check("brp_not_taken_pc", {28'd0, pc}, 32'd3);
    instr();
    instr();
    check("brz_taken_pc", {28'd0, pc}, 32'd8);
    instr();
    check("brz_halted", {31'd0, halted}, 32'd1);
    check("brz_halt_pc", {28'd0, pc}, 32'd9);

    // Branch to the last word, HLT there, pc wraps.
    clear_prog();
    prog[0] = 8'h6F;
    load_prog();
    start_run();
    instr();
    check("wrap_bra_pc", {28'd0, pc}, 32'd15);
    instr();
    check("wrap_halted", {31'd0, halted}, 32'd1);
    check("wrap_pc", {28'd0, pc}, 32'd0);

    // run and load together in IDLE: load wins, then run alone starts.
    reset_dut();
    load_valid = 1'b1;
    run        = 1'b1;
    load_addr  = 4'd5;
    load_data  = 8'h77;
    #1;
    check("prio_ready", {31'd0, load_ready}, 32'd1);
    check("prio_we", {31'd0, ram_we}, 32'd1);
    cyc();
    run = 1'b0;
    check("prio_mem5", {24'd0, mem[5]}, 32'h77);
    #1;
    check("prio_still_idle", {31'd0, load_ready}, 32'd1);
    cyc();
    load_valid = 1'b0;
    start_run();
    load_valid = 1'b1;
    #1;
    check("prio_fetch_no_ready", {31'd0, load_ready}, 32'd0);
    check("prio_fetch_no_we", {31'd0, ram_we}, 32'd0);
    load_valid = 1'b0;
    reset_dut();

    // Reset during the EXEC cycle of STA suppresses the write.
    clear_prog();
    prog[0] = 8'h5A; prog[1] = 8'h3D; prog[10] = 8'h33; prog[13] = 8'h11;
    load_prog();
    start_run();
    cyc();
    cyc();
    cyc();
    check("sta_we_pending", {31'd0, ram_we}, 32'd1);
    reset_count = 1'b1;
    #1;
    check("sta_we_suppressed", {31'd0, ram_we}, 32'd0);
    cyc();
    reset_count = 1'b0;
    model_reset();
    check("sta_memD", {24'd0, mem[13]}, 32'h11);
    check("sta_rst_pc", {28'd0, pc}, 32'd0);
    check("sta_rst_acc", {24'd0, acc}, 32'd0);
    check("sta_rst_halted", {31'd0, halted}, 32'd0);

    // Random programs; each word doubles as instruction and data.
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
      load_prog();
      run_against_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lmc_sequencer.md
LMC_SEQUENCER -- requirements
Module: lmc_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SHALL set the program RAM address width.
REQ-002 Parameter DATA_WIDTH, default 8, SHALL set the RAM word and accumulator width; the opcode is bits [7:4] and the operand is bits [3:0].
REQ-003 Ports SHALL be:
  timer555  in  1  sole clock, rising edge.
  reset_count  in  1  synchronous, active-high reset.
  run  in  1  start-execution request from PC=0.
  load_valid  in  1  loader write request.
  load_ready  out  1  loader request accepted this cycle.
  load_addr  in  ADDR_WIDTH  loader write address.
  load_data  in  DATA_WIDTH  loader write data.
  ram_addr  out  ADDR_WIDTH  RAM address.
  ram_wdata  out  DATA_WIDTH  RAM write data.
  ram_we  out  1  RAM write strobe; the RAM writes on the rising edge of timer555.
  ram_rdata  in  DATA_WIDTH  asynchronous RAM read data at ram_addr.
  pc  out  ADDR_WIDTH  program counter.
  acc  out  DATA_WIDTH  accumulator.
  out_data  out  DATA_WIDTH  OUT instruction register.
  out_valid  out  1  one-cycle pulse when out_data is updated.
  halted  out  1  high in HALT state.

Function
REQ-004 The FSM SHALL have four states: IDLE, FETCH, EXEC and HALT.
REQ-005 In IDLE or HALT, when load_valid=1, the block SHALL assert load_ready, ram_we=1, ram_addr=load_addr and ram_wdata=load_data in the same cycle, and stay in its current state.
REQ-006 In IDLE or HALT, when run=1 and load_valid=0, the block SHALL set pc to 0 and go to FETCH on the next cycle.
REQ-007 If load_valid and run are both 1, the load SHALL win and run SHALL be ignored for that cycle.
REQ-008 In FETCH, the block SHALL drive ram_addr=pc, set ir to ram_rdata, increment pc modulo 2^ADDR_WIDTH (15 wraps to 0) and go to EXEC.
REQ-009 In EXEC, ram_addr SHALL equal ir[3:0], and the opcode SHALL act as follows:
  - 0 HLT: go to HALT.
  - 1 ADD: acc <= acc + ram_rdata, wrapping modulo 2^DATA_WIDTH.
  - 2 SUB: acc <= acc - ram_rdata; set neg if a borrow occurs, otherwise clear neg.
  - 3 STA: ram_we=1, ram_wdata=acc.
  - 5 LDA: acc <= ram_rdata; clear neg.
  - 6 BRA: pc <= operand.
  - 7 BRZ: pc <= operand if acc==0.
  - 8 BRP: pc <= operand if neg==0.
  - 9 OUT: out_data <= acc; pulse out_valid.
  - Any other opcode: no operation.
REQ-010 Every EXEC except HLT SHALL return to FETCH, so each instruction takes exactly 2 cycles.
REQ-011 ADD SHALL clear neg; BRZ and BRP SHALL test the values present at the start of EXEC.
REQ-012 load_ready SHALL be 0 in FETCH and EXEC, and load_valid SHALL be ignored in those states.
REQ-013 Outside REQ-005 and STA, ram_we SHALL be 0.
REQ-014 ram_wdata SHALL be 0 when ram_we=0.
REQ-015 halted SHALL be 1 only in HALT.

Reset
REQ-016 When reset_count=1 at a rising edge, the block SHALL set state=IDLE and pc, acc, ir, neg and out_data to 0, and out_valid, load_ready and ram_we to 0. This applies from any state, including mid-instruction; a pending STA write SHALL be suppressed in the reset cycle.
REQ-017 reset_count SHALL take priority over run and load_valid.

Configuration
REQ-018 With LMC_SEQ_STEP_EN defined, the block SHALL add an input port step (1 bit). FETCH SHALL then hold, with no state change, until a cycle in which step=1, and each step pulse SHALL execute exactly one instruction.
REQ-019 With LMC_SEQ_STEP_EN undefined, the step port SHALL be absent and FETCH SHALL proceed every cycle.

Structure
REQ-020 A shared package lmc_pkg SHALL hold the opcode constants (HLT, ADD, SUB, STA, LDA, BRA, BRZ, BRP, OUT) and the FSM state encodings.
REQ-021 The ALU SHALL be a sub-module, lmc_alu, that is combinational: inputs acc, operand, opcode; outputs result and neg_next.
REQ-022 The RAM SHALL remain external to this block.

Verification
REQ-023 Load scenario: in IDLE, load_valid=1, load_addr=3, load_data=8'h5A -> load_ready=1 and ram_we=1 in the same cycle, and RAM[3]=8'h5A.
REQ-024 Program scenario: program {0:8'h5A, 1:8'h1B, 2:8'h3C, 3:8'h90, 4:8'h00, A:8'd7, B:8'd5}, then run -> halted=1 after 10 cycles, acc=12, RAM[C]=12, and out_valid pulses once with out_data=12.
REQ-025 SUB/branch scenario: acc=3, SUB with RAM value 5 -> acc=8'hFE and neg=1, and a following BRP is not taken; with acc=0, BRZ to 8 -> pc=8.
REQ-026 Wrap scenario: BRA 15 with RAM[15]=8'h00 -> HLT fetched at 15 and pc wraps to 0.
REQ-027 Reset scenario: reset_count=1 in an EXEC cycle of STA -> no RAM write, and state=IDLE, pc=0, acc=0 on the next cycle.
REQ-028 Priority scenario: run=1 and load_valid=1 in the same IDLE cycle -> the write occurs, state stays IDLE, and a run alone on the next cycle starts FETCH.
